// File: rtl/scaler_line_ctrl.sv
// Ping-pong line-buffer controller: writes a pixel line into one RAM bank while
// resampling the other bank out through a fixed-point step accumulator.
module scaler_line_ctrl #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAC_BITS  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [10:0]           cfg_src_w,
    input  logic [10:0]           cfg_dst_w,
    input  logic [15:0]           cfg_step,
    input  logic [3:0]            cfg_vrep,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_eol,
    output logic [ADDR_WIDTH-1:0] ram_a_addr,
    output logic [DATA_WIDTH-1:0] ram_a_wr_data,
    output logic                  ram_a_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_b_addr,
    input  logic [DATA_WIDTH-1:0] ram_b_rd_data,
    output logic [1:0]            bank_full
);

    localparam int unsigned COL_W = ADDR_WIDTH - 1;
    localparam int unsigned CFG_W = 11;
    localparam int unsigned ACC_W = 27;
    localparam int unsigned IDX_W = ACC_W - FRAC_BITS;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_LINE  = 2'd1,
        R_DRAIN = 2'd2
    } rstate_e;

    rstate_e              state_q, state_d;
    logic [1:0]           bank_full_q, bank_full_d;
    logic                 w_bank_q, w_bank_d;
    logic [COL_W-1:0]     w_col_q, w_col_d;
    logic                 r_bank_q, r_bank_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CFG_W-1:0]     o_col_q, o_col_d;
    logic [3:0]           pass_q, pass_d;
    logic                 inflight_q, inflight_d;
    logic                 inflight_eol_q, inflight_eol_d;
    logic [1:0]           occ_q, occ_d;
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [1:0]           fifo_eol_q;

    logic                 w_hs;
    logic                 w_last;
    logic                 set_bank;
    logic                 clr_bank;
    logic                 issue;
    logic                 issue_ok;
    logic                 o_col_last;
    logic                 pop;
    logic                 push;
    logic [CFG_W-1:0]     src_last;
    logic [IDX_W-1:0]     idx_raw;
    logic [COL_W-1:0]     idx;
    logic [2:0]           credit;

    // Write side: port A is driven straight from the input stream.
    assign s_ready       = ~bank_full_q[w_bank_q];
    assign w_hs          = s_valid & s_ready;
    assign w_last        = (CFG_W'(w_col_q) == (cfg_src_w - CFG_W'(1)));
    assign ram_a_addr    = {w_bank_q, w_col_q};
    assign ram_a_wr_data = s_data;
    assign ram_a_wr_en   = w_hs;
    assign bank_full     = bank_full_q;

    // Source index is the integer part of the accumulator, clamped to the line end.
    assign src_last   = cfg_src_w - CFG_W'(1);
    assign idx_raw    = IDX_W'(acc_q >> FRAC_BITS);
    assign idx        = (idx_raw > IDX_W'(src_last)) ? COL_W'(src_last) : COL_W'(idx_raw);
    assign ram_b_addr = {r_bank_q, idx};
    assign o_col_last = (o_col_q == (cfg_dst_w - CFG_W'(1)));

    // Never issue more reads than the FIFO can absorb once they return.
    assign pop      = m_valid & m_ready;
    assign push     = inflight_q;
    assign credit   = 3'({1'b0, occ_q}) + 3'(inflight_q) - 3'(pop);
    assign issue_ok = (credit < 3'd2);

    assign m_valid = (occ_q != 2'd0);
    assign m_data  = fifo_data_q[rptr_q];
    assign m_eol   = fifo_eol_q[rptr_q] & m_valid;

    always_comb begin
        w_col_d  = w_col_q;
        w_bank_d = w_bank_q;
        set_bank = 1'b0;
        if (w_hs) begin
            if (w_last) begin
                w_col_d  = '0;
                w_bank_d = ~w_bank_q;
                set_bank = 1'b1;
            end else begin
                w_col_d = w_col_q + COL_W'(1);
            end
        end
    end

    // Read FSM next-state and datapath.
    always_comb begin
        state_d        = state_q;
        r_bank_d       = r_bank_q;
        acc_d          = acc_q;
        o_col_d        = o_col_q;
        pass_d         = pass_q;
        issue          = 1'b0;
        clr_bank       = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bank_full_q[r_bank_q]) begin
                    acc_d   = '0;
                    o_col_d = '0;
                    pass_d  = '0;
                    state_d = R_LINE;
                end
            end
            R_LINE: begin
                if (issue_ok) begin
                    issue   = 1'b1;
                    acc_d   = acc_q + ACC_W'(cfg_step);
                    o_col_d = o_col_q + CFG_W'(1);
                    if (o_col_last) begin
                        if (pass_q < cfg_vrep) begin
                            pass_d  = pass_q + 4'd1;
                            acc_d   = '0;
                            o_col_d = '0;
                        end else begin
                            state_d = R_DRAIN;
                        end
                    end
                end
            end
            R_DRAIN: begin
                clr_bank = 1'b1;
                r_bank_d = ~r_bank_q;
                state_d  = R_IDLE;
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    // Set and clear always target different banks, so both apply.
    always_comb begin
        bank_full_d = bank_full_q;
        if (set_bank) begin
            bank_full_d[w_bank_q] = 1'b1;
        end
        if (clr_bank) begin
            bank_full_d[r_bank_q] = 1'b0;
        end
    end

    always_comb begin
        inflight_d     = issue;
        inflight_eol_d = issue & o_col_last;
        occ_d          = occ_q + 2'(push) - 2'(pop);
        wptr_d         = push ? ~wptr_q : wptr_q;
        rptr_d         = pop ? ~rptr_q : rptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= R_IDLE;
            bank_full_q    <= '0;
            w_bank_q       <= 1'b0;
            w_col_q        <= '0;
            r_bank_q       <= 1'b0;
            acc_q          <= '0;
            o_col_q        <= '0;
            pass_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_eol_q <= 1'b0;
            occ_q          <= '0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bank_full_q    <= bank_full_d;
            w_bank_q       <= w_bank_d;
            w_col_q        <= w_col_d;
            r_bank_q       <= r_bank_d;
            acc_q          <= acc_d;
            o_col_q        <= o_col_d;
            pass_q         <= pass_d;
            inflight_q     <= inflight_d;
            inflight_eol_q <= inflight_eol_d;
            occ_q          <= occ_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
        end
    end

    // Output FIFO storage; RAM data is captured in the cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_eol_q     <= '0;
        end else if (push) begin
            fifo_data_q[wptr_q] <= ram_b_rd_data;
            fifo_eol_q[wptr_q]  <= inflight_eol_q;
        end
    end

endmodule

// File: doc/scaler_line_ctrl.md
# scaler_line_ctrl

Ping-pong line-buffer controller for the video scaler's 2048x8 dual-port line RAM. It writes an incoming pixel stream into one half (bank) of the RAM through port A while reading the other bank through port B. Reads use a fixed-point step accumulator for horizontal resampling and an integer line-repeat count for vertical upscale. The block sits between the capture/decoder stream and the scaler output stage, and is the sole master of both RAM ports.

## Interface

Parameters:
- ADDR_WIDTH, 11, RAM address width; bank select is MSB, bank size 2^(ADDR_WIDTH-1) = 1024.
- DATA_WIDTH, 8, pixel width.
- FRAC_BITS, 12, fractional bits of cfg_step (Q4.12).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high (ports `clk` and `rst`).
  - clk  in  1  system clock; all logic on rising edge.
  - rst  in  1  asynchronous, active-high reset.
- Configuration:
  - cfg_src_w  in  11  source pixels per line, 1..1024.
  - cfg_dst_w  in  11  output pixels per line pass, 1..2047.
  - cfg_step  in  16  source advance per output pixel, Q4.12, nonzero.
  - cfg_vrep  in  4  extra read passes per line; each line is output cfg_vrep+1 times.
- Input stream:
  - s_valid  in  1  input pixel valid.
  - s_ready  out  1  input accept.
  - s_data  in  DATA_WIDTH  input pixel.
- Output stream:
  - m_valid  out  1  output pixel valid.
  - m_ready  in  1  output accept.
  - m_data  out  DATA_WIDTH  output pixel.
  - m_eol  out  1  qualifies the last pixel of each line pass.
- RAM ports:
  - ram_a_addr  out  ADDR_WIDTH  port A address, equal to {w_bank, w_col}.
  - ram_a_wr_data  out  DATA_WIDTH  equal to s_data.
  - ram_a_wr_en  out  1  equal to s_valid & s_ready.
  - ram_b_addr  out  ADDR_WIDTH  port B read address.
  - ram_b_rd_data  in  DATA_WIDTH  port B data, valid the cycle after the address is presented (no output register).
- Status:
  - bank_full  out  2  per-bank "line complete, not yet released".

Port B write enable and port A read data are unused and tied off at the top level.

## Operation

- Config is quasi-static. It may change only when the block is idle: bank_full=0, w_col=0, read FSM in R_IDLE, FIFO empty. Otherwise behaviour is undefined.
- Write side:
  - Registers: w_bank (1 bit) and w_col (10 bits).
  - s_ready = !bank_full[w_bank].
  - RAM port A outputs are combinational from s_*.
  - On each handshake, w_col increments.
  - On the handshake with w_col == cfg_src_w-1: w_col clears, bank_full[w_bank] sets, and w_bank toggles.
- Read FSM, with registers r_bank, acc (27 bits), o_col (11 bits) and pass (4 bits):
  - R_IDLE: if bank_full[r_bank], clear acc, o_col and pass, then go to R_LINE.
  - R_LINE: in each cycle that issue is permitted, present ram_b_addr = {r_bank, idx}.
    - idx = min(acc>>FRAC_BITS, cfg_src_w-1).
    - acc saturates-free, since 27 bits covers 2047 * 0xFFFF.
    - acc += cfg_step; o_col++.
    - After issuing o_col == cfg_dst_w-1: if pass < cfg_vrep, pass++ and clear acc and o_col (stay in R_LINE); else go to R_DRAIN.
  - R_DRAIN: one cycle, in which the last read data is captured. Then clear bank_full[r_bank], toggle r_bank, and go to R_IDLE.
- Read issue and output FIFO:
  - Issue permitted when occ + inflight - pop < 2, where occ is the 2-entry output FIFO occupancy, inflight is the read issued last cycle, and pop = m_valid & m_ready.
  - This gives full throughput under continuous m_ready.
  - Returned data is pushed into the FIFO together with an eol tag (set on o_col == cfg_dst_w-1).
  - m_valid = (occ != 0). m_data and m_eol come from the FIFO head.
- Simultaneous events:
  - A write-side set and a read-side clear of bank_full in the same cycle always target different banks; both take effect.
  - FIFO push and pop in the same cycle leave occ unchanged.
- Reset values:
  - bank_full=0, w_bank=0, w_col=0, r_bank=0, state R_IDLE, occ=0, inflight=0.
  - Resulting outputs: s_ready=1, m_valid=0, m_eol=0, ram_a_wr_en=0, ram_b_addr=0.
- Reset mid-operation discards all partial lines and FIFO contents immediately (asynchronous).

## Timing

- For the last write handshake of a line in cycle T:
  - bank_full bit is high in T+1.
  - R_LINE is entered, with the first read issued, in T+2.
  - The data is pushed at the end of T+3.
  - m_valid is first high in T+4.
- Steady state with m_ready=1: one output pixel per cycle per line pass. A 2-cycle bubble (R_DRAIN, R_IDLE) occurs between banks.
- The writer stalls (s_ready=0) only while both banks are full.

## Test plan

- Identity: src=8, dst=8, step=0x1000, vrep=0, input 0..7 → m_data 0..7, m_eol only on 7, first m_valid 4 cycles after the last input handshake.
- 2x upscale: src=4, dst=8, step=0x0800, input 10,20,30,40 → 10,10,20,20,30,30,40,40.
- Downscale and clamp: src=8, dst=3, step=0x2AAB → source indices 0,2,5. Separately, src=4, dst=6, step=0x1000 → indices 0,1,2,3,3,3.
- Vertical repeat and ping-pong: src=4, dst=4, step=0x1000, vrep=1, lines A and B pushed back-to-back → A output twice, then B twice, 4 m_eol pulses total, bank_full returns to 0.
- Backpressure: hold m_ready=0 and push 3 lines of src=4 → 8 pixels accepted, then s_ready=0 and bank_full=2'b11, FIFO holds 2 entries. Randomize m_ready → no loss or duplication, and the third line is accepted after the first bank is released.
- Reset mid-line: assert rst after 2 of 4 pixels → all outputs return to reset values immediately. A following full line is output correctly from bank 0.
